// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the iterative RV32M multiply/divide unit.
//   muldiv_op_t    - funct3 encodings of the M-extension ops
//   muldiv_state_t - control FSM states
//   MULDIV_ITERS   - iterations per multiply/divide
package muldiv_pkg;

   localparam int unsigned MULDIV_ITERS = 32;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PREP = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } muldiv_state_t;

   // Divide class (DIV/DIVU/REM/REMU) versus multiply class.
   function automatic logic is_div(input muldiv_op_t op);
      return (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU});
   endfunction

   // Remainder-returning ops.
   function automatic logic is_rem(input muldiv_op_t op);
      return (op inside {OP_REM, OP_REMU});
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply (radix-2 shift-add) / divide (restoring)
// in the execute stage. 32 iterations per op; divide-by-zero and signed
// overflow resolve early.
//   clk, rst        - clock, synchronous active-high reset
//   startE          - M-extension op in execute (sampled only in IDLE)
//   funct3E         - op select (muldiv_op_t encoding)
//   rd1E, rd2E      - operand A (multiplicand/dividend), operand B (multiplier/divisor)
//   flushE          - abort any operation
//   stallM          - combinational hold for fetch/decode/ID-EX register
//   doneE, resultE  - registered one-cycle done pulse and result
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = MULDIV_ITERS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  startE,
   input  logic [2:0]            funct3E,
   input  logic [DATA_WIDTH-1:0] rd1E,
   input  logic [DATA_WIDTH-1:0] rd2E,
   input  logic                  flushE,
   output logic                  stallM,
   output logic                  doneE,
   output logic [DATA_WIDTH-1:0] resultE
);

   localparam int unsigned W  = DATA_WIDTH;
   localparam int unsigned AW = 2 * DATA_WIDTH;
   localparam int unsigned CW = $clog2(DATA_WIDTH);
   localparam logic [W-1:0] INT_MIN = {1'b1, {(W-1){1'b0}}};

   muldiv_state_t state_q, state_d;
   muldiv_op_t    op_q, op_d;
   logic [W-1:0]  a_q, a_d, b_q, b_d;
   logic [W-1:0]  mag_q, mag_d;     // |multiplicand| or |divisor|
   logic [AW-1:0] acc_q, acc_d;     // {hi, lo}: product, or {remainder, quotient}
   logic [CW-1:0] cnt_q, cnt_d;
   logic          neg_q, neg_d;     // negate the selected result word(s)
   logic [W-1:0]  result_q, result_d;
   logic          done_q, done_d;

   logic [AW-1:0] acc_step;
   logic [W:0]    mul_sum, div_trial, div_diff;
   logic          sign_a, sign_b;
   logic [W-1:0]  abs_a, abs_b;

   // Sign-correct the accumulator and pick the word the op returns.
   function automatic logic [W-1:0] finalize(input muldiv_op_t op,
                                             input logic [AW-1:0] acc,
                                             input logic neg);
      logic [AW-1:0] prod;
      logic [W-1:0]  quo, rem;
      prod = neg ? (~acc + AW'(1)) : acc;
      quo  = neg ? (~acc[W-1:0] + W'(1)) : acc[W-1:0];
      rem  = neg ? (~acc[AW-1:W] + W'(1)) : acc[AW-1:W];
      case (op)
         OP_MUL:                       return prod[W-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: return prod[AW-1:W];
         OP_DIV, OP_DIVU:              return quo;
         default:                      return rem;
      endcase
   endfunction

   // One iteration: add-then-shift-right for multiply, shift-left/compare/subtract for divide.
   always_comb begin
      mul_sum   = {1'b0, acc_q[AW-1:W]} + (acc_q[0] ? {1'b0, mag_q} : {(W+1){1'b0}});
      div_trial = acc_q[AW-1:W-1];
      div_diff  = div_trial - {1'b0, mag_q};
      if (is_div(op_q)) begin
         if (div_trial >= {1'b0, mag_q}) acc_step = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
         else                             acc_step = {div_trial[W-1:0], acc_q[W-2:0], 1'b0};
      end else begin
         acc_step = {mul_sum, acc_q[W-1:1]};
      end
   end

   // Next-state and datapath control.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      mag_d    = mag_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      result_d = result_q;
      done_d   = 1'b0;
      sign_a   = a_q[W-1] & (op_q inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
      sign_b   = b_q[W-1] & (op_q inside {OP_MULH, OP_DIV, OP_REM});
      abs_a    = sign_a ? (~a_q + W'(1)) : a_q;
      abs_b    = sign_b ? (~b_q + W'(1)) : b_q;

      case (state_q)
         IDLE: begin
            if (startE) begin
               op_d    = muldiv_op_t'(funct3E);
               a_d     = rd1E;
               b_d     = rd2E;
               state_d = PREP;
            end
         end
         PREP: begin
            cnt_d   = '0;
            state_d = RUN;
            if (is_div(op_q)) begin
               acc_d = {W'(0), abs_a};
               mag_d = abs_b;
               neg_d = is_rem(op_q) ? sign_a : (sign_a ^ sign_b);
            end else begin
               acc_d = {W'(0), abs_b};
               mag_d = abs_a;
               neg_d = sign_a ^ sign_b;
            end
            if (is_div(op_q) && (b_q == '0)) begin
               state_d  = DONE;
               done_d   = 1'b1;
               result_d = is_rem(op_q) ? a_q : '1;
            end else if ((op_q inside {OP_DIV, OP_REM}) && (a_q == INT_MIN) && (b_q == '1)) begin
               state_d  = DONE;
               done_d   = 1'b1;
               result_d = (op_q == OP_DIV) ? INT_MIN : '0;
            end
         end
         RUN: begin
            acc_d = acc_step;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
               state_d  = DONE;
               done_d   = 1'b1;
               result_d = finalize(op_q, acc_step, neg_q);
            end
         end
         default: state_d = IDLE;
      endcase

      // Abort: no completion, result holds.
      if (flushE) begin
         state_d  = IDLE;
         done_d   = 1'b0;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         op_q     <= OP_MUL;
         a_q      <= '0;
         b_q      <= '0;
         mag_q    <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         mag_q    <= mag_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         result_q <= result_d;
         done_q   <= done_d;
      end
   end

   // Combinational so the issuing instruction holds in its own cycle.
   assign stallM  = ((state_q == IDLE) & startE & ~flushE) | (state_q == PREP) | (state_q == RUN);
   assign doneE   = done_q;
   assign resultE = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit. Expected results are
// queued when an op is issued and compared when doneE pulses.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        rst, startE, flushE;
   logic [2:0]  funct3E;
   logic [31:0] rd1E, rd2E, resultE;
   logic        stallM, doneE;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] res;
      int          lat;
   } exp_t;

   exp_t        scoreboard[$];
   logic [31:0] last_exp;

   muldiv_unit #(.DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .startE(startE), .funct3E(funct3E),
      .rd1E(rd1E), .rd2E(rd2E), .flushE(flushE),
      .stallM(stallM), .doneE(doneE), .resultE(resultE)
   );

   always #5 clk = ~clk;

   // Reference model built on native 64-bit and signed arithmetic.
   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic [63:0]        sa, sbv, ua, ub, p;
      logic signed [31:0] q;
      logic               ovf;
      sa  = {{32{a[31]}}, a};
      sbv = {{32{b[31]}}, b};
      ua  = {32'h0, a};
      ub  = {32'h0, b};
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f)
         3'd0: begin p = sa * sbv; return p[31:0];  end
         3'd1: begin p = sa * sbv; return p[63:32]; end
         3'd2: begin p = sa * ub;  return p[63:32]; end
         3'd3: begin p = ua * ub;  return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return 32'h8000_0000;
            q = $signed(a) / $signed(b);
            return q;
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'h0;
            q = $signed(a) % $signed(b);
            return q;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (f[2] && (b == 0)) return 2;
      if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
      return 34;
   endfunction

   // Drive one start cycle (entered just after a rising edge, DUT in IDLE);
   // returns stallM seen in that start cycle. Operands are scrambled afterwards.
   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, output logic s0);
      startE  = 1'b1;
      funct3E = f;
      rd1E    = a;
      rd2E    = b;
      @(negedge clk);
      s0 = stallM;
      @(posedge clk); #1;
      startE  = 1'b0;
      funct3E = 3'($urandom);
      rd1E    = $urandom;
      rd2E    = $urandom;
   endtask

   // Wait for doneE (bounded); lat counts cycles since the start cycle.
   // Returns positioned at the falling edge of the done cycle.
   task automatic wait_done(output int lat, output bit ok, output int stalls);
      lat = 0; ok = 1'b0; stalls = 0;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (doneE) begin
            lat = i;
            ok  = 1'b1;
            break;
         end
         if (stallM) stalls++;
         @(posedge clk); #1;
      end
   endtask

   // Count doneE pulses over n idle cycles.
   task automatic count_done(input int n, output int pulses);
      pulses = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (doneE) pulses++;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (resultE !== 32'h0) begin failures++; $display("FAIL reset_result: got %h expected %h", resultE, 32'h0); end
      checks++; if (doneE !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", doneE); end
      checks++; if (stallM !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b expected 0", stallM); end
      @(posedge clk); #1;
      rst = 1'b0;
      startE = 1'b1; flushE = 1'b1;
      @(negedge clk);
      checks++; if (stallM !== 1'b0) begin failures++; $display("FAIL stall_flush_gate: got %b expected 0", stallM); end
      flushE = 1'b0; #1;
      checks++; if (stallM !== 1'b1) begin failures++; $display("FAIL stall_idle_start: got %b expected 1", stallM); end
      startE = 1'b0; #1;
      checks++; if (stallM !== 1'b0) begin failures++; $display("FAIL stall_idle_nostart: got %b expected 0", stallM); end
      @(posedge clk); #1;
      last_exp = 32'h0;
   endtask

   task automatic test_mul();
      logic [2:0]  fs [4] = '{3'd0, 3'd3, 3'd1, 3'd2};
      logic [31:0] as [4] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] bs [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2};
      logic [31:0] rs [4] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF};
      logic s0; int lat, stalls; bit ok; exp_t e;
      for (int i = 0; i < 4; i++) begin
         scoreboard.push_back('{rs[i], 34});
         issue(fs[i], as[i], bs[i], s0);
         wait_done(lat, ok, stalls);
         e = scoreboard.pop_front();
         checks++;
         if (!ok) begin failures++; $display("FAIL mul%0d_timeout: no doneE, expected result %h", i, e.res); end
         else begin
            if (resultE !== e.res) begin failures++; $display("FAIL mul%0d_result: got %h expected %h", i, resultE, e.res); end
            checks++; if (lat !== e.lat) begin failures++; $display("FAIL mul%0d_latency: got %0d expected %0d", i, lat, e.lat); end
            last_exp = e.res;
         end
         if (i == 0) begin
            checks++; if (s0 !== 1'b1) begin failures++; $display("FAIL mul_stall_cycle0: got %b expected 1", s0); end
            checks++; if (stalls !== 33) begin failures++; $display("FAIL mul_stall_cycles: got %0d expected 33", stalls); end
            checks++; if (stallM !== 1'b0) begin failures++; $display("FAIL mul_stall_done: got %b expected 0", stallM); end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_div();
      logic [2:0]  fs [8] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
      logic [31:0] as [8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                              32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] bs [8] = '{32'd2, 32'd2, 32'd7, 32'd7,
                              32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] rs [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                              32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
      int          ls [8] = '{34, 34, 34, 34, 2, 2, 2, 2};
      logic s0; int lat, stalls; bit ok; exp_t e;
      for (int i = 0; i < 8; i++) begin
         scoreboard.push_back('{rs[i], ls[i]});
         issue(fs[i], as[i], bs[i], s0);
         wait_done(lat, ok, stalls);
         e = scoreboard.pop_front();
         checks++;
         if (!ok) begin failures++; $display("FAIL div%0d_timeout: no doneE, expected result %h", i, e.res); end
         else begin
            if (resultE !== e.res) begin failures++; $display("FAIL div%0d_result: got %h expected %h", i, resultE, e.res); end
            checks++; if (lat !== e.lat) begin failures++; $display("FAIL div%0d_latency: got %0d expected %0d", i, lat, e.lat); end
            last_exp = e.res;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_random();
      logic [2:0] f; logic [31:0] a, b;
      logic s0; int lat, stalls; bit ok; exp_t e;
      for (int i = 0; i < 16; i++) begin
         f = 3'(i % 8);
         a = $urandom;
         b = (i == 13) ? 32'h0 : $urandom;
         if (i % 3 == 0) b = b >> $urandom_range(28, 1);
         scoreboard.push_back('{model(f, a, b), model_lat(f, a, b)});
         issue(f, a, b, s0);
         wait_done(lat, ok, stalls);
         e = scoreboard.pop_front();
         checks++;
         if (!ok) begin failures++; $display("FAIL rnd%0d_timeout: f=%0d a=%h b=%h no doneE", i, f, a, b); end
         else begin
            if (resultE !== e.res) begin failures++; $display("FAIL rnd%0d_result: f=%0d a=%h b=%h got %h expected %h", i, f, a, b, resultE, e.res); end
            checks++; if (lat !== e.lat) begin failures++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, e.lat); end
            last_exp = e.res;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_flush();
      logic s0; int lat, stalls, pulses; bit ok; exp_t e;
      issue(3'd4, 32'hFFFF_FFF9, 32'd2, s0);   // cycle 1 (PREP)
      repeat (11) begin @(posedge clk); #1; end // cycle 12: RUN, counter 10
      flushE = 1'b1;
      @(posedge clk); #1;
      flushE = 1'b0;
      @(negedge clk);
      checks++; if (stallM !== 1'b0) begin failures++; $display("FAIL flush_stall: got %b expected 0", stallM); end
      checks++; if (doneE !== 1'b0) begin failures++; $display("FAIL flush_done: got %b expected 0", doneE); end
      checks++; if (resultE !== last_exp) begin failures++; $display("FAIL flush_result_hold: got %h expected %h", resultE, last_exp); end
      @(posedge clk); #1;
      count_done(40, pulses);
      checks++; if (pulses !== 0) begin failures++; $display("FAIL flush_no_done: got %0d pulses expected 0", pulses); end
      scoreboard.push_back('{32'd12, 34});
      issue(3'd0, 32'd3, 32'd4, s0);
      wait_done(lat, ok, stalls);
      e = scoreboard.pop_front();
      checks++;
      if (!ok) begin failures++; $display("FAIL flush_next_timeout: no doneE, expected %h", e.res); end
      else begin
         if (resultE !== e.res) begin failures++; $display("FAIL flush_next_result: got %h expected %h", resultE, e.res); end
         checks++; if (lat !== e.lat) begin failures++; $display("FAIL flush_next_latency: got %0d expected %0d", lat, e.lat); end
         last_exp = e.res;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_start_ignored();
      logic s0; int lat, stalls, pulses; bit ok; exp_t e;
      scoreboard.push_back('{32'd30, 34});
      issue(3'd0, 32'd5, 32'd6, s0);            // cycle 1
      repeat (9) begin @(posedge clk); #1; end  // cycle 10, RUN
      startE = 1'b1; funct3E = 3'd5; rd1E = 32'd1000; rd2E = 32'd10;
      @(posedge clk); #1;                       // cycle 11
      startE = 1'b0;
      wait_done(lat, ok, stalls);
      e = scoreboard.pop_front();
      checks++;
      if (!ok) begin failures++; $display("FAIL ign_timeout: no doneE, expected %h", e.res); end
      else begin
         if (resultE !== e.res) begin failures++; $display("FAIL ign_result: got %h expected %h", resultE, e.res); end
         checks++; if (lat + 10 !== e.lat) begin failures++; $display("FAIL ign_latency: got %0d expected %0d", lat + 10, e.lat); end
         last_exp = e.res;
      end
      @(posedge clk); #1;
      count_done(40, pulses);
      checks++; if (pulses !== 0) begin failures++; $display("FAIL ign_extra_done: got %0d pulses expected 0", pulses); end
   endtask

   task automatic test_rst_mid();
      logic s0; int pulses;
      issue(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, s0);
      repeat (5) begin @(posedge clk); #1; end  // RUN
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++; if (resultE !== 32'h0) begin failures++; $display("FAIL rst_mid_result: got %h expected %h", resultE, 32'h0); end
      checks++; if (doneE !== 1'b0) begin failures++; $display("FAIL rst_mid_done: got %b expected 0", doneE); end
      checks++; if (stallM !== 1'b0) begin failures++; $display("FAIL rst_mid_stall: got %b expected 0", stallM); end
      @(posedge clk); #1;
      count_done(40, pulses);
      checks++; if (pulses !== 0) begin failures++; $display("FAIL rst_mid_no_done: got %0d pulses expected 0", pulses); end
      last_exp = 32'h0;
   endtask

   task automatic test_back_to_back();
      logic s0; int lat, stalls; bit ok; exp_t e;
      scoreboard.push_back('{32'd14, 34});
      scoreboard.push_back('{32'd2, 34});
      issue(3'd5, 32'd100, 32'd7, s0);
      for (int k = 0; k < 2; k++) begin
         wait_done(lat, ok, stalls);
         e = scoreboard.pop_front();
         checks++;
         if (!ok) begin failures++; $display("FAIL b2b%0d_timeout: no doneE, expected %h", k, e.res); end
         else begin
            if (resultE !== e.res) begin failures++; $display("FAIL b2b%0d_result: got %h expected %h", k, resultE, e.res); end
            checks++; if (lat !== e.lat) begin failures++; $display("FAIL b2b%0d_latency: got %0d expected %0d", k, lat, e.lat); end
            last_exp = e.res;
         end
         @(posedge clk); #1;
         if (k == 0) issue(3'd7, 32'd100, 32'd7, s0);   // first IDLE cycle after DONE
      end
      @(negedge clk);
      checks++; if (doneE !== 1'b0) begin failures++; $display("FAIL b2b_pulse_width: got %b expected 0", doneE); end
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; startE = 1'b0; flushE = 1'b0;
      funct3E = 3'd0; rd1E = 32'h0; rd2E = 32'h0;
      last_exp = 32'h0;
      test_reset();
      test_mul();
      test_div();
      test_random();
      test_flush();
      test_start_ignored();
      test_rst_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
